// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared encodings and constants for the HI/LO multiply/divide sequencer
package multdiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PREP  = 2'b01,
    ST_ITER  = 2'b10,
    ST_FIXUP = 2'b11
  } state_e;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

  // Magnitude of a 32-bit operand; unsigned ops pass through untouched.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - ID-stage issue, HI/LO access and status bundle
interface multdiv_if;
  logic        Start_IN;
  logic [1:0]  Op_IN;
  logic [31:0] OperandA_IN;
  logic [31:0] OperandB_IN;
  logic        ReadHiLo_IN;
  logic        WriteHi_IN;
  logic        WriteLo_IN;
  logic [31:0] WriteData_IN;
  logic        Busy_OUT;
  logic        StallRequest_OUT;
  logic        Done_OUT;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  modport master (
    output Start_IN, Op_IN, OperandA_IN, OperandB_IN,
    output ReadHiLo_IN, WriteHi_IN, WriteLo_IN, WriteData_IN,
    input  Busy_OUT, StallRequest_OUT, Done_OUT, HI_OUT, LO_OUT
  );

  modport slave (
    input  Start_IN, Op_IN, OperandA_IN, OperandB_IN,
    input  ReadHiLo_IN, WriteHi_IN, WriteLo_IN, WriteData_IN,
    output Busy_OUT, StallRequest_OUT, Done_OUT, HI_OUT, LO_OUT
  );
endinterface

// File: rtl/multdiv_iter_step.sv
// rtl/multdiv_iter_step.sv - one combinational shift-add or restoring-divide iteration
module multdiv_iter_step (
  input  logic        i_is_div,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_operand_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  // Multiply: {hi,lo} is the partial product with the multiplier shifting out of lo.
  // Divide:   hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  logic [32:0] w_sum;
  logic [32:0] w_shifted;
  logic [32:0] w_diff;

  assign w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand_b} : 33'd0);
  assign w_shifted = {i_hi, i_lo[31]};
  assign w_diff    = w_shifted - {1'b0, i_operand_b};

  // Select the divide or multiply update; a borrow in w_diff means the subtract is undone.
  always_comb begin
    o_hi = w_sum[32:1];
    o_lo = {w_sum[0], i_lo[31:1]};
    if (i_is_div) begin
      if (!w_diff[32]) begin
        o_hi = w_diff[31:0];
        o_lo = {i_lo[30:0], 1'b1};
      end else begin
        o_hi = w_shifted[31:0];
        o_lo = {i_lo[30:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - 34-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
module multdiv_sequencer
  import multdiv_pkg::*;
(
  input logic      CLOCK,
  input logic      RESET,
  multdiv_if.slave bus
);
  state_e      r_state, w_next_state;
  op_e         r_op;
  logic [4:0]  r_count;
  logic [31:0] r_a, r_b;
  logic [31:0] r_acc_hi, r_acc_lo, r_mag_b;
  logic [31:0] r_hi, r_lo;
  logic        r_done;

  logic        w_is_div, w_is_signed, w_sign_a, w_sign_b, w_last_iter;
  logic [31:0] w_step_hi, w_step_lo;
  logic [63:0] w_prod, w_prod_neg;
  logic [31:0] w_fix_hi, w_fix_lo;

  assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_is_signed = (r_op == OP_DIV) || (r_op == OP_MULT);
  assign w_sign_a    = w_is_signed & r_a[31];
  assign w_sign_b    = w_is_signed & r_b[31];
  assign w_last_iter = (r_count == 5'(ITER_COUNT - 1));
  assign w_prod      = {r_acc_hi, r_acc_lo};
  assign w_prod_neg  = ~w_prod + 64'd1;

  multdiv_iter_step u_step (
    .i_is_div    (w_is_div),
    .i_hi        (r_acc_hi),
    .i_lo        (r_acc_lo),
    .i_operand_b (r_mag_b),
    .o_hi        (w_step_hi),
    .o_lo        (w_step_lo)
  );

  // State register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state: starts are only honoured from IDLE; ITER runs until the counter's last value.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.Start_IN) w_next_state = ST_PREP;
      ST_PREP:  w_next_state = ST_ITER;
      ST_ITER:  if (w_last_iter) w_next_state = ST_FIXUP;
      ST_FIXUP: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Sign correction of the magnitude result; a zero divisor bypasses the datapath entirely.
  always_comb begin
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (w_is_div) begin
      if (r_b == 32'd0) begin
        w_fix_hi = r_a;
        w_fix_lo = DIV0_LO;
      end else begin
        w_fix_lo = (w_sign_a ^ w_sign_b) ? (~r_acc_lo + 32'd1) : r_acc_lo;
        w_fix_hi = w_sign_a ? (~r_acc_hi + 32'd1) : r_acc_hi;
      end
    end else if (w_sign_a ^ w_sign_b) begin
      w_fix_hi = w_prod_neg[63:32];
      w_fix_lo = w_prod_neg[31:0];
    end
  end

  // Operand capture, iteration datapath, counter and architectural HI/LO.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_op     <= OP_MULT;
      r_a      <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mag_b  <= '0;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.WriteHi_IN) r_hi <= bus.WriteData_IN;
          if (bus.WriteLo_IN) r_lo <= bus.WriteData_IN;
          if (bus.Start_IN) begin
            r_op <= op_e'(bus.Op_IN);
            r_a  <= bus.OperandA_IN;
            r_b  <= bus.OperandB_IN;
          end
        end
        ST_PREP: begin
          r_acc_hi <= '0;
          r_acc_lo <= mag32(r_a, w_is_signed);
          r_mag_b  <= mag32(r_b, w_is_signed);
          r_count  <= '0;
        end
        ST_ITER: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_count  <= r_count + 5'd1;
        end
        ST_FIXUP: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  // Completion pulse lands in the cycle after the HI/LO update.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) r_done <= 1'b0;
    else       r_done <= (r_state == ST_FIXUP);
  end

  assign bus.Busy_OUT         = (r_state != ST_IDLE);
  assign bus.StallRequest_OUT = bus.Busy_OUT &
                                (bus.ReadHiLo_IN | bus.Start_IN | bus.WriteHi_IN | bus.WriteLo_IN);
  assign bus.Done_OUT         = r_done;
  assign bus.HI_OUT           = r_hi;
  assign bus.LO_OUT           = r_lo;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - directed self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;
  import multdiv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multdiv_if bus ();

  multdiv_sequencer dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start at the coming edge (E0); return at the falling edge after E0 with operands scrambled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start_IN    = 1'b1;
    bus.Op_IN       = op;
    bus.OperandA_IN = a;
    bus.OperandB_IN = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start_IN    = 1'b0;
    bus.Op_IN       = ~op;
    bus.OperandA_IN = ~a;
    bus.OperandB_IN = b ^ 32'h5A5A_0F0F;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.Done_OUT !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.Busy_OUT !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy_OUT); end
    checks++; if (bus.Done_OUT !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.Done_OUT); end
    checks++; if (bus.HI_OUT !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.HI_OUT); end
    checks++; if (bus.LO_OUT !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.LO_OUT); end
    checks++; if (bus.StallRequest_OUT !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.StallRequest_OUT); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mult();
    int cyc;
    @(negedge clk);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    // A stray start while busy must be ignored.
    @(negedge clk);
    bus.Start_IN = 1'b1; bus.Op_IN = OP_DIVU; bus.OperandA_IN = 32'd9; bus.OperandB_IN = 32'd2;
    checks++; if (bus.Busy_OUT !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b expected 1", bus.Busy_OUT); end
    @(negedge clk);
    bus.Start_IN = 1'b0;
    wait_done(cyc);
    cyc += 2;
    checks++; if (cyc !== 34) begin errors++; $display("FAIL mult_latency: got %0d expected 34", cyc); end
    checks++; if (bus.HI_OUT !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", bus.HI_OUT); end
    checks++; if (bus.LO_OUT !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", bus.LO_OUT); end
    checks++; if (bus.Busy_OUT !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b expected 0", bus.Busy_OUT); end
    @(negedge clk);
    checks++; if (bus.Done_OUT !== 1'b0) begin errors++; $display("FAIL mult_done_width: got %b expected 0", bus.Done_OUT); end
  endtask

  task automatic test_divide();
    int cyc;
    // DIVU 100/7
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL divu_latency: got %0d expected 34", cyc); end
    checks++; if (bus.LO_OUT !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", bus.LO_OUT); end
    checks++; if (bus.HI_OUT !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", bus.HI_OUT); end
    @(negedge clk);
    // DIV -7/2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    checks++; if (bus.LO_OUT !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", bus.LO_OUT); end
    checks++; if (bus.HI_OUT !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", bus.HI_OUT); end
    @(negedge clk);
    // DIV 5/0
    issue(OP_DIV, 32'd5, 32'd0);
    wait_done(cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL div0_latency: got %0d expected 34", cyc); end
    checks++; if (bus.HI_OUT !== 32'd5) begin errors++; $display("FAIL div0_hi: got %h expected 00000005", bus.HI_OUT); end
    checks++; if (bus.LO_OUT !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", bus.LO_OUT); end
    @(negedge clk);
    // DIV most-negative / -1
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    checks++; if (bus.LO_OUT !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.LO_OUT); end
    checks++; if (bus.HI_OUT !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", bus.HI_OUT); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int cyc;
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    bus.ReadHiLo_IN = 1'b1;
    #1;
    cyc = 0;
    while (bus.Done_OUT !== 1'b1 && cyc < 100) begin
      checks++; if (bus.StallRequest_OUT !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1 at cycle %0d", bus.StallRequest_OUT, cyc); end
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL stall_latency: got %0d expected 34", cyc); end
    checks++; if (bus.StallRequest_OUT !== 1'b0) begin errors++; $display("FAIL stall_done: got %b expected 0", bus.StallRequest_OUT); end
    checks++; if (bus.HI_OUT !== 32'h1) begin errors++; $display("FAIL stall_hi: got %h expected 00000001", bus.HI_OUT); end
    checks++; if (bus.LO_OUT !== 32'h0) begin errors++; $display("FAIL stall_lo: got %h expected 00000000", bus.LO_OUT); end
    bus.ReadHiLo_IN = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_hilo();
    int cyc;
    bus.WriteHi_IN = 1'b1; bus.WriteData_IN = 32'h1234_5678;
    @(negedge clk);
    bus.WriteHi_IN = 1'b0;
    checks++; if (bus.HI_OUT !== 32'h1234_5678) begin errors++; $display("FAIL mthi: got %h expected 12345678", bus.HI_OUT); end
    bus.WriteLo_IN = 1'b1; bus.WriteData_IN = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.WriteLo_IN = 1'b0;
    checks++; if (bus.LO_OUT !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo: got %h expected 9abcdef0", bus.LO_OUT); end
    // Write together with start: write lands now, result overwrites later.
    bus.WriteHi_IN = 1'b1; bus.WriteData_IN = 32'h0000_AAAA;
    issue(OP_MULTU, 32'd2, 32'd3);
    bus.WriteHi_IN = 1'b0;
    checks++; if (bus.HI_OUT !== 32'h0000_AAAA) begin errors++; $display("FAIL mthi_with_start: got %h expected 0000aaaa", bus.HI_OUT); end
    bus.WriteLo_IN = 1'b1; bus.WriteData_IN = 32'h0000_5555;
    #1;
    checks++; if (bus.StallRequest_OUT !== 1'b1) begin errors++; $display("FAIL mtlo_busy_stall: got %b expected 1", bus.StallRequest_OUT); end
    @(negedge clk);
    @(negedge clk);
    bus.WriteLo_IN = 1'b0;
    checks++; if (bus.LO_OUT !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_busy_ignored: got %h expected 9abcdef0", bus.LO_OUT); end
    wait_done(cyc);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL write_op_latency: got %0d expected 32", cyc); end
    checks++; if (bus.HI_OUT !== 32'h0) begin errors++; $display("FAIL write_op_hi: got %h expected 00000000", bus.HI_OUT); end
    checks++; if (bus.LO_OUT !== 32'd6) begin errors++; $display("FAIL write_op_lo: got %h expected 00000006", bus.LO_OUT); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int cyc;
    int done_seen;
    issue(OP_MULT, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.Busy_OUT !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.Busy_OUT); end
    checks++; if (bus.HI_OUT !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h expected 0", bus.HI_OUT); end
    checks++; if (bus.LO_OUT !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h expected 0", bus.LO_OUT); end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done_OUT === 1'b1) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
    checks++; if (bus.LO_OUT !== 32'h0) begin errors++; $display("FAIL abort_lo_kept: got %h expected 0", bus.LO_OUT); end
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL post_abort_latency: got %0d expected 34", cyc); end
    checks++; if (bus.LO_OUT !== 32'd12) begin errors++; $display("FAIL post_abort_lo: got %h expected 0000000c", bus.LO_OUT); end
    checks++; if (bus.HI_OUT !== 32'h0) begin errors++; $display("FAIL post_abort_hi: got %h expected 00000000", bus.HI_OUT); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 34", cyc); end
    bus.Start_IN = 1'b1; bus.Op_IN = OP_MULT; bus.OperandA_IN = 32'hFFFF_FFFD; bus.OperandB_IN = 32'd7;
    #1;
    checks++; if (bus.StallRequest_OUT !== 1'b0) begin errors++; $display("FAIL b2b_no_stall: got %b expected 0", bus.StallRequest_OUT); end
    checks++; if (bus.LO_OUT !== 32'd14) begin errors++; $display("FAIL b2b_first_lo: got %h expected 0000000e", bus.LO_OUT); end
    checks++; if (bus.HI_OUT !== 32'd2) begin errors++; $display("FAIL b2b_first_hi: got %h expected 00000002", bus.HI_OUT); end
    @(posedge clk);
    @(negedge clk);
    bus.Start_IN = 1'b0; bus.OperandA_IN = 32'd0; bus.OperandB_IN = 32'd0;
    gap = 1;
    checks++; if (bus.Busy_OUT !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus.Busy_OUT); end
    wait_done(cyc);
    gap += cyc;
    checks++; if (gap !== 35) begin errors++; $display("FAIL b2b_gap: got %0d expected 35", gap); end
    checks++; if (bus.HI_OUT !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second_hi: got %h expected ffffffff", bus.HI_OUT); end
    checks++; if (bus.LO_OUT !== 32'hFFFF_FFEB) begin errors++; $display("FAIL b2b_second_lo: got %h expected ffffffeb", bus.LO_OUT); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.Start_IN     = 1'b0;
    bus.Op_IN        = 2'b00;
    bus.OperandA_IN  = 32'd0;
    bus.OperandB_IN  = 32'd0;
    bus.ReadHiLo_IN  = 1'b0;
    bus.WriteHi_IN   = 1'b0;
    bus.WriteLo_IN   = 1'b0;
    bus.WriteData_IN = 32'd0;
    test_reset();
    test_mult();
    test_divide();
    test_stall();
    test_write_hilo();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
